// File: rtl/detector_sentido.sv
// Parking lane direction decoder: debounced beam pair into a crossing FSM
// emitting one-cycle entrada/salida/error pulses and an ocupado flag.
module detector_sentido #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_ext,
  input  logic sensor_int,
  output logic entrada,
  output logic salida,
  output logic error,
  output logic ocupado
);

  typedef enum logic [2:0] {
    IDLE,
    E1,
    E2,
    E3,
    S1,
    S2,
    S3,
    WAIT_CLR
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_IN,
    EV_OUT,
    EV_ERR
  } ev_t;

  logic [1:0] raw;
  logic [1:0] filt;
  logic       ext_f;
  logic       int_f;

  assign raw   = {sensor_ext, sensor_int};
  assign ext_f = filt[1];
  assign int_f = filt[0];

  genvar g;
  for (g = 0; g < 2; g++) begin : g_deb
    logic             s1;
    logic             s2;
    logic             f;
    logic [CNT_W-1:0] cnt;

    // Two-flop sync, then accept a new level only after DEBOUNCE stable cycles
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        f   <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        if (s2 == f) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
          f   <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign filt[g] = f;
  end

  state_t           state;
  state_t           nxt;
  ev_t              ev;
  logic [CNT_W-1:0] tcnt;
  logic             chain;

  assign chain = (state != IDLE) && (state != WAIT_CLR);

  // Next state and event from the filtered beam pair, timeout last
  always_comb begin
    nxt = state;
    ev  = EV_NONE;
    unique case (state)
      IDLE: begin
        case ({ext_f, int_f})
          2'b10:   nxt = E1;
          2'b01:   nxt = S1;
          2'b11: begin
            nxt = WAIT_CLR;
            ev  = EV_ERR;
          end
          default: nxt = IDLE;
        endcase
      end
      E1: begin
        case ({ext_f, int_f})
          2'b11:   nxt = E2;
          2'b00:   nxt = IDLE;
          2'b01: begin
            nxt = WAIT_CLR;
            ev  = EV_ERR;
          end
          default: nxt = E1;
        endcase
      end
      E2: begin
        case ({ext_f, int_f})
          2'b01:   nxt = E3;
          2'b10:   nxt = E1;
          2'b00: begin
            nxt = WAIT_CLR;
            ev  = EV_ERR;
          end
          default: nxt = E2;
        endcase
      end
      E3: begin
        case ({ext_f, int_f})
          2'b00: begin
            nxt = IDLE;
            ev  = EV_IN;
          end
          2'b11:   nxt = E2;
          2'b10: begin
            nxt = WAIT_CLR;
            ev  = EV_ERR;
          end
          default: nxt = E3;
        endcase
      end
      S1: begin
        case ({ext_f, int_f})
          2'b11:   nxt = S2;
          2'b00:   nxt = IDLE;
          2'b10: begin
            nxt = WAIT_CLR;
            ev  = EV_ERR;
          end
          default: nxt = S1;
        endcase
      end
      S2: begin
        case ({ext_f, int_f})
          2'b10:   nxt = S3;
          2'b01:   nxt = S1;
          2'b00: begin
            nxt = WAIT_CLR;
            ev  = EV_ERR;
          end
          default: nxt = S2;
        endcase
      end
      S3: begin
        case ({ext_f, int_f})
          2'b00: begin
            nxt = IDLE;
            ev  = EV_OUT;
          end
          2'b11:   nxt = S2;
          2'b01: begin
            nxt = WAIT_CLR;
            ev  = EV_ERR;
          end
          default: nxt = S3;
        endcase
      end
      default: begin
        if ({ext_f, int_f} == 2'b00) nxt = IDLE;
      end
    endcase
    if (chain && nxt == state &&
        tcnt == CNT_W'(TIMEOUT - 1)) begin
      nxt = WAIT_CLR;
      ev  = EV_ERR;
    end
  end

  // State, dwell counter and registered pulse outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tcnt    <= '0;
      entrada <= 1'b0;
      salida  <= 1'b0;
      error   <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      state   <= nxt;
      entrada <= (ev == EV_IN);
      salida  <= (ev == EV_OUT);
      error   <= (ev == EV_ERR);
      ocupado <= (nxt != IDLE);
      if (nxt != state || !chain) tcnt <= '0;
      else                        tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_detector_sentido.sv
// Directed bench for detector_sentido: crossings, reversal, bounce,
// timeout, invalid start and asynchronous reset.
module tb_detector_sentido;

  logic clk;
  logic reset;
  logic sensor_ext;
  logic sensor_int;
  logic entrada;
  logic salida;
  logic error;
  logic ocupado;

  int total;
  int bad;
  int cyc;
  int n_in;
  int n_out;
  int n_err;
  int n_occ;
  int in_cyc;
  int out_cyc;
  int err_cyc;
  int mark;

  detector_sentido #(
    .DEBOUNCE(4),
    .TIMEOUT (50),
    .CNT_W   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sensor_ext(sensor_ext),
    .sensor_int(sensor_int),
    .entrada   (entrada),
    .salida    (salida),
    .error     (error),
    .ocupado   (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (entrada) begin
        n_in   <= n_in + 1;
        in_cyc <= cyc;
      end
      if (salida) begin
        n_out   <= n_out + 1;
        out_cyc <= cyc;
      end
      if (error) begin
        n_err   <= n_err + 1;
        err_cyc <= cyc;
      end
      if (ocupado) n_occ <= n_occ + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic i);
    sensor_ext = e;
    sensor_int = i;
  endtask

  task automatic clr_counts;
    @(negedge clk);
    n_in  = 0;
    n_out = 0;
    n_err = 0;
    n_occ = 0;
    in_cyc  = -1;
    out_cyc = -1;
    err_cyc = -1;
  endtask

  task automatic inbound;
    drive(1, 0); tick(20);
    drive(1, 1); tick(20);
    drive(0, 1); tick(20);
    drive(0, 0);
    mark = cyc;
    tick(20);
  endtask

  task automatic test_reset;
    total++;
    if ({entrada, salida, error, ocupado} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_state got=%b want=0000",
               {entrada, salida, error, ocupado});
    end
    clr_counts();
    drive(1, 0); tick(20);
    drive(1, 1); tick(20);
    total++;
    if (ocupado !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_busy got=%b want=1", ocupado);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({entrada, salida, error, ocupado} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async got=%b want=0000",
               {entrada, salida, error, ocupado});
    end
    @(negedge clk);
    drive(0, 0);
    reset = 1'b1;
    tick(10);
    total++;
    if (ocupado !== 1'b0 || n_err !== 0) begin
      bad++;
      $display("FAIL reset_idle got occ=%b err=%0d want 0/0",
               ocupado, n_err);
    end
    clr_counts();
    inbound();
    total++;
    if (n_in !== 1 || n_out !== 0 || n_err !== 0) begin
      bad++;
      $display("FAIL reset_then_in got in=%0d out=%0d err=%0d want 1/0/0",
               n_in, n_out, n_err);
    end
  endtask

  task automatic test_inbound;
    clr_counts();
    inbound();
    total++;
    if (n_in !== 1 || n_out !== 0 || n_err !== 0) begin
      bad++;
      $display("FAIL in_counts got in=%0d out=%0d err=%0d want 1/0/0",
               n_in, n_out, n_err);
    end
    total++;
    if (in_cyc - mark !== 7) begin
      bad++;
      $display("FAIL in_latency got=%0d want=7", in_cyc - mark);
    end
    total++;
    if (ocupado !== 1'b0) begin
      bad++;
      $display("FAIL in_idle got=%b want=0", ocupado);
    end
  endtask

  task automatic test_outbound;
    clr_counts();
    drive(0, 1); tick(20);
    drive(1, 1); tick(20);
    drive(1, 0); tick(20);
    drive(0, 0);
    mark = cyc;
    tick(20);
    total++;
    if (n_in !== 0 || n_out !== 1 || n_err !== 0) begin
      bad++;
      $display("FAIL out_counts got in=%0d out=%0d err=%0d want 0/1/0",
               n_in, n_out, n_err);
    end
    total++;
    if (out_cyc - mark !== 7) begin
      bad++;
      $display("FAIL out_latency got=%0d want=7", out_cyc - mark);
    end
  endtask

  task automatic test_reversal;
    clr_counts();
    drive(1, 0); tick(20);
    drive(1, 1); tick(20);
    drive(1, 0); tick(20);
    total++;
    if (ocupado !== 1'b1) begin
      bad++;
      $display("FAIL rev_busy got=%b want=1", ocupado);
    end
    drive(0, 0); tick(20);
    total++;
    if (n_in !== 0 || n_out !== 0 || n_err !== 0) begin
      bad++;
      $display("FAIL rev_counts got in=%0d out=%0d err=%0d want 0/0/0",
               n_in, n_out, n_err);
    end
    total++;
    if (ocupado !== 1'b0) begin
      bad++;
      $display("FAIL rev_idle got=%b want=0", ocupado);
    end
  endtask

  task automatic test_bounce;
    clr_counts();
    for (int k = 0; k < 15; k++) begin
      drive(~sensor_ext, 0);
      tick(2);
    end
    drive(0, 0);
    tick(20);
    total++;
    if (n_occ !== 0 || n_in !== 0 || n_out !== 0 || n_err !== 0) begin
      bad++;
      $display("FAIL bounce got occ=%0d in=%0d out=%0d err=%0d want all 0",
               n_occ, n_in, n_out, n_err);
    end
  endtask

  task automatic test_timeout;
    clr_counts();
    drive(1, 0);
    mark = cyc;
    tick(100);
    total++;
    if (n_err !== 1 || err_cyc - mark !== 57) begin
      bad++;
      $display("FAIL timeout got n=%0d at=%0d want 1 at 57",
               n_err, err_cyc - mark);
    end
    total++;
    if (ocupado !== 1'b1) begin
      bad++;
      $display("FAIL timeout_hold got=%b want=1", ocupado);
    end
    drive(0, 0); tick(20);
    total++;
    if (ocupado !== 1'b0 || n_err !== 1 || n_in !== 0) begin
      bad++;
      $display("FAIL timeout_exit got occ=%b err=%0d in=%0d want 0/1/0",
               ocupado, n_err, n_in);
    end
  endtask

  task automatic test_both_start;
    clr_counts();
    drive(1, 1);
    mark = cyc;
    tick(20);
    total++;
    if (n_err !== 1 || err_cyc - mark !== 7) begin
      bad++;
      $display("FAIL both_err got n=%0d at=%0d want 1 at 7",
               n_err, err_cyc - mark);
    end
    total++;
    if (ocupado !== 1'b1) begin
      bad++;
      $display("FAIL both_wait got=%b want=1", ocupado);
    end
    drive(0, 1); tick(20);
    total++;
    if (ocupado !== 1'b1 || n_err !== 1) begin
      bad++;
      $display("FAIL both_stay got occ=%b err=%0d want 1/1",
               ocupado, n_err);
    end
    drive(0, 0); tick(20);
    total++;
    if (ocupado !== 1'b0 || n_err !== 1 || n_out !== 0) begin
      bad++;
      $display("FAIL both_exit got occ=%b err=%0d out=%0d want 0/1/0",
               ocupado, n_err, n_out);
    end
  endtask

  task automatic test_back_to_back;
    clr_counts();
    inbound();
    inbound();
    total++;
    if (n_in !== 2 || n_out !== 0 || n_err !== 0) begin
      bad++;
      $display("FAIL b2b got in=%0d out=%0d err=%0d want 2/0/0",
               n_in, n_out, n_err);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    n_in  = 0;
    n_out = 0;
    n_err = 0;
    n_occ = 0;
    in_cyc  = -1;
    out_cyc = -1;
    err_cyc = -1;
    mark  = 0;
    reset = 1'b0;
    drive(0, 0);
    tick(3);
    test_reset_pre();
    reset = 1'b1;
    tick(2);
    test_reset();
    test_inbound();
    test_outbound();
    test_reversal();
    test_bounce();
    test_timeout();
    test_both_start();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic test_reset_pre;
    total++;
    if ({entrada, salida, error, ocupado} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hold got=%b want=0000",
               {entrada, salida, error, ocupado});
    end
  endtask

endmodule
